// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for an 8-bit FIFO with one-cycle read latency.
// Issues single-cycle fifo_rd strobes and captures fifo_dout the following cycle
// into a 2-entry skid buffer. Bytes are then presented on a valid/ready stream.
// Because the buffer reserves room for the in-flight byte before each read,
// back-pressure never drops or duplicates data.
//
// Optional feature: define FIFO_READER_STATS_EN to build a 16-bit delivered-byte
// counter on byte_cnt. The counter increments on every pop and wraps. When the
// macro is undefined, byte_cnt is tied to zero and no register is built.
module fifo_reader #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic [15:0]   byte_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic [1:0]    r_count;
    logic          r_inflight;
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [DW-1:0] r_mem [2];

    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_level;

    // Stream side: the head of the skid buffer is always the presented byte.
    // Pushes only ever write the tail, so the head stays stable under back-pressure.
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign busy      = r_busy;

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight;

    // Occupancy after this cycle's pop, counting the byte already requested.
    // count + inflight never exceeds 2, so 2-bit arithmetic cannot wrap.
    assign w_level = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

    // A read is only issued when the returned byte is guaranteed a free slot.
    assign fifo_rd = (r_state == ST_RUN) && en && !fifo_empty && (w_level < 2'd2);

    // Run/drain control; busy is registered alongside the state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: the default arm keeps the case fully specified, so an
            // illegal encoding recovers to IDLE instead of holding an undefined value.
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        r_state <= ST_RUN;
                    end else if (!r_inflight && (r_count == 2'd0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Track the read issued last cycle; its data arrives on fifo_dout now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd;
        end
    end

    // Skid buffer pointers and occupancy. A simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Skid buffer storage: the captured FIFO byte is written into the tail entry.
    // NOTE: both entries are reset because out_data exposes the head directly
    // and must read as zero after reset; only two registers are involved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_dout;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [15:0] r_byte_cnt;

    // Delivered-byte counter; wraps naturally at 16 bits and is cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 16'd0;
        end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
        end
    end

    assign byte_cnt = r_byte_cnt;
`else
    assign byte_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed testbench for fifo_reader. A small FIFO model with one-cycle read
// latency feeds the DUT. Inputs change and outputs are sampled in the low clock phase.
module tb_fifo_reader;

`ifdef FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic [15:0] byte_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: the initial block writes entries, and the clocked block consumes them.
    logic [7:0] fmem [16];
    int         f_wr_idx = 0;
    int         f_rd_idx = 0;
    logic       tb_inf   = 1'b0;

    fifo_reader #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .byte_cnt   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = tb_inf ? 1'b0 : (f_rd_idx == f_wr_idx);

    always @(posedge clk) begin
        if (rst) begin
            f_rd_idx <= f_wr_idx;
        end else if (fifo_rd) begin
            if (tb_inf) begin
                fifo_dout <= 8'hA5;
            end else begin
                fifo_dout <= fmem[f_rd_idx[3:0]];
                f_rd_idx  <= f_rd_idx + 1;
            end
        end
    end

    task automatic load(input logic [7:0] b);
        fmem[f_wr_idx[3:0]] = b;
        f_wr_idx = f_wr_idx + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd_pulses;
        int pops;
        bit done;

        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        fifo_dout = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        rst = 1'b0;
        #1;
        chk("rst_fifo_rd",   {31'd0, fifo_rd},   32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_byte_cnt",  {16'd0, byte_cnt},  32'd0);

        // Streaming three bytes with out_ready held high
        load(8'h11); load(8'h22); load(8'h33);
        @(negedge clk);
        en = 1'b1; out_ready = 1'b1;
        #1;
        chk("s1_idle_no_rd", {31'd0, fifo_rd}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk($sformatf("s1_rd_%0d", i),    {31'd0, fifo_rd},   {31'd0, (i < 3)});
            chk($sformatf("s1_valid_%0d", i), {31'd0, out_valid}, {31'd0, (i >= 2 && i <= 4)});
            chk($sformatf("s1_busy_%0d", i),  {31'd0, busy},      32'd1);
            if (i >= 2 && i <= 4)
                chk($sformatf("s1_data_%0d", i), {24'd0, out_data}, 32'h11 * (i - 1));
        end

        // Empty FIFO with en=1: no reads, nothing valid
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("empty_rd_%0d", i),    {31'd0, fifo_rd},   32'd0);
            chk($sformatf("empty_valid_%0d", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: five bytes, out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        load(8'h41); load(8'h42); load(8'h43); load(8'h44); load(8'h45);
        rd_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (fifo_rd) rd_pulses++;
            chk($sformatf("bp_rd_%0d", i),    {31'd0, fifo_rd},   {31'd0, (i < 2)});
            chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, {31'd0, (i >= 2)});
            if (i >= 2)
                chk($sformatf("bp_hold_%0d", i), {24'd0, out_data}, 32'h41);
        end
        chk("bp_rd_pulses", rd_pulses, 32'd2);

        // Release back-pressure: all five bytes delivered in order, no gaps
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("rel_rd_%0d", i),    {31'd0, fifo_rd},   {31'd0, (i < 3)});
            chk($sformatf("rel_valid_%0d", i), {31'd0, out_valid}, {31'd0, (i < 5)});
            if (i < 5)
                chk($sformatf("rel_data_%0d", i), {24'd0, out_data}, 32'h41 + i);
        end

        // Drop en the cycle after a read: in-flight byte delivered, then IDLE
        @(negedge clk);
        load(8'h51); load(8'h52); load(8'h53);
        #1;
        chk("drop_rd0", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("drop_rd1",    {31'd0, fifo_rd},   32'd0);
        chk("drop_busy1",  {31'd0, busy},      32'd1);
        chk("drop_valid1", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        chk("drop_rd2",    {31'd0, fifo_rd},   32'd0);
        chk("drop_valid2", {31'd0, out_valid}, 32'd1);
        chk("drop_data2",  {24'd0, out_data},  32'h51);
        chk("drop_busy2",  {31'd0, busy},      32'd1);
        @(negedge clk); #1;
        chk("drop_rd3",    {31'd0, fifo_rd},   32'd0);
        chk("drop_valid3", {31'd0, out_valid}, 32'd0);
        chk("drop_busy3",  {31'd0, busy},      32'd1);
        for (int i = 4; i < 6; i++) begin
            @(negedge clk); #1;
            chk($sformatf("drop_rd%0d", i),   {31'd0, fifo_rd}, 32'd0);
            chk($sformatf("drop_busy%0d", i), {31'd0, busy},    32'd0);
        end
        chk("cnt_before_rst", {16'd0, byte_cnt}, STATS ? 32'd9 : 32'd0);

        // Reset while holding bytes in the buffer and one in flight
        load(8'h54);
        @(negedge clk);
        en = 1'b1; out_ready = 1'b0;
        #1;
        chk("mr_rd0", {31'd0, fifo_rd}, 32'd0);
        @(negedge clk); #1;
        chk("mr_rd1", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk); #1;
        chk("mr_rd2", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk); #1;
        chk("mr_rd3",    {31'd0, fifo_rd},   32'd0);
        chk("mr_valid3", {31'd0, out_valid}, 32'd1);
        chk("mr_data3",  {24'd0, out_data},  32'h52);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_rd",    {31'd0, fifo_rd},   32'd0);
        chk("mr_busy",  {31'd0, busy},      32'd0);
        chk("mr_data",  {24'd0, out_data},  32'd0);
        chk("mr_cnt",   {16'd0, byte_cnt},  32'd0);
        rst = 1'b0; en = 1'b0;

        // After reset, a fresh byte is the first one delivered
        @(negedge clk);
        load(8'h61);
        en = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_rd0",    {31'd0, fifo_rd},   32'd0);
        chk("post_valid0", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        chk("post_rd1", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk); #1;
        chk("post_rd2",    {31'd0, fifo_rd},   32'd0);
        chk("post_valid2", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        chk("post_valid3", {31'd0, out_valid}, 32'd1);
        chk("post_data3",  {24'd0, out_data},  32'h61);
        @(negedge clk); #1;
        chk("post_valid4", {31'd0, out_valid}, 32'd0);
        chk("post_cnt",    {16'd0, byte_cnt},  STATS ? 32'd1 : 32'd0);

`ifdef FIFO_READER_STATS_EN
        // 65536 more pops on top of the one above: the 16-bit counter wraps to 1
        tb_inf = 1'b1;
        pops = 0;
        done = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk); #1;
            if (out_valid) begin
                if (pops == 65536) begin
                    out_ready = 1'b0;
                    en = 1'b0;
                    done = 1'b1;
                    break;
                end
                pops++;
            end
        end
        tb_inf = 1'b0;
        chk("wrap_done", {31'd0, done}, 32'd1);
        @(negedge clk); #1;
        chk("wrap_cnt", {16'd0, byte_cnt}, 32'h0001);
`else
        pops = 0;
        done = 1'b0;
        chk("nostats_cnt", {16'd0, byte_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
